// File: rtl/contador_modulo_param.sv
// contador_modulo_param: modulo-N up/down counter with a prescaler, clear, load, tick and terminal-count pulses
module contador_modulo_param #(
    parameter int WIDTH    = 6,
    parameter int MODULO   = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             tc_o
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    if (WIDTH < 1 || WIDTH > 16 || MODULO < 2 || MODULO > (1 << WIDTH) ||
        PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_params
        $error("contador_modulo_param: illegal parameter set");
    end

    logic [PW-1:0]    pre;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] nxt;

    // wrap is decided by comparison, so MODULO = 2**WIDTH never needs a wider sum
    always_comb begin
        step = en_i && pre == PMAX;
        wrap = up_i ? count_o == MAX : count_o == '0;
        nxt  = wrap ? (up_i ? '0 : MAX) : (up_i ? count_o + WIDTH'(1) : count_o - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_o <= '0;
            pre     <= '0;
            tick_o  <= 1'b0;
            tc_o    <= 1'b0;
        end else if (load_i) begin
            count_o <= load_val_i > MAX ? MAX : load_val_i;
            pre     <= '0;
            tick_o  <= 1'b0;
            tc_o    <= 1'b0;
        end else begin
            tick_o <= step;
            tc_o   <= step && wrap;
            if (en_i) pre <= step ? '0 : pre + PW'(1);
            if (step) count_o <= nxt;
        end
    end
endmodule

// File: tb/tb_contador_modulo_param.sv
// tb_contador_modulo_param: three counter configurations checked against a reference model plus directed corner cases
module tb_contador_modulo_param;
    int mods[3] = '{10, 10, 16};
    int pres[3] = '{1, 4, 1};

    logic clk = 1'b0;
    logic rst, en, up, clr, ld;
    logic [5:0] lv;
    logic [5:0] cnt_a, cnt_b;
    logic [3:0] cnt_c;
    logic tick_a, tick_b, tick_c, tc_a, tc_b, tc_c;

    always #5 clk = ~clk;

    contador_modulo_param #(.WIDTH(6), .MODULO(10), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv), .count_o(cnt_a), .tick_o(tick_a), .tc_o(tc_a));
    contador_modulo_param #(.WIDTH(6), .MODULO(10), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv), .count_o(cnt_b), .tick_o(tick_b), .tc_o(tc_b));
    contador_modulo_param #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u_c (
        .clk(clk), .rst(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv[3:0]), .count_o(cnt_c), .tick_o(tick_c), .tc_o(tc_c));

    typedef struct {
        int cnt;
        bit tick;
        bit tc;
    } exp_t;

    typedef struct {
        logic en;
        logic up;
        int   cnt;
        bit   tick;
        bit   tc;
    } vec_t;

    exp_t qa[$], qb[$], qc[$];
    int m_cnt[3], m_pre[3];
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, expv);
        end
    endtask

    task automatic model(input int i, input logic r, e, u, c, l, input logic [5:0] v, output exp_t x);
        int lvv;
        x.tick = 0;
        x.tc = 0;
        lvv = (i == 2) ? int'(v[3:0]) : int'(v);
        if (r || c) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end else if (l) begin
            m_cnt[i] = lvv >= mods[i] ? mods[i] - 1 : lvv;
            m_pre[i] = 0;
        end else if (e) begin
            if (m_pre[i] == pres[i] - 1) begin
                m_pre[i] = 0;
                m_cnt[i] = u ? (m_cnt[i] + 1) % mods[i] : (m_cnt[i] + mods[i] - 1) % mods[i];
                x.tick = 1;
                x.tc = u ? m_cnt[i] == 0 : m_cnt[i] == mods[i] - 1;
            end else begin
                m_pre[i]++;
            end
        end
        x.cnt = m_cnt[i];
    endtask

    task automatic drive(input logic r, e, u, c, l, input logic [5:0] v);
        exp_t x;
        rst = r; en = e; up = u; clr = c; ld = l; lv = v;
        model(0, r, e, u, c, l, v, x); qa.push_back(x);
        model(1, r, e, u, c, l, v, x); qb.push_back(x);
        model(2, r, e, u, c, l, v, x); qc.push_back(x);
        @(posedge clk);
        #1;
        x = qa.pop_front();
        chk("a_cnt", 32'(cnt_a), x.cnt); chk("a_tick", 32'(tick_a), 32'(x.tick)); chk("a_tc", 32'(tc_a), 32'(x.tc));
        x = qb.pop_front();
        chk("b_cnt", 32'(cnt_b), x.cnt); chk("b_tick", 32'(tick_b), 32'(x.tick)); chk("b_tc", 32'(tc_b), 32'(x.tc));
        x = qc.pop_front();
        chk("c_cnt", 32'(cnt_c), x.cnt); chk("c_tick", 32'(tick_c), 32'(x.tick)); chk("c_tc", 32'(tc_c), 32'(x.tc));
    endtask

    vec_t tv[25];

    initial begin
        for (int k = 0; k < 25; k++) tv[k] = '{1'b1, 1'b1, (k + 1) % 10, 1'b1, (k + 1) % 10 == 0};
        rst = 1; en = 0; up = 1; clr = 0; ld = 0; lv = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 0, 0, 0);
        chk("reset_cnt_a", 32'(cnt_a), 0);
        chk("reset_tick_tc_b", 32'({tick_b, tc_b}), 0);

        // table: up count through two wraps
        for (int k = 0; k < 25; k++) begin
            drive(0, tv[k].en, tv[k].up, 0, 0, 0);
            chk("tab_cnt", 32'(cnt_a), tv[k].cnt);
            chk("tab_tick", 32'(tick_a), 32'(tv[k].tick));
            chk("tab_tc", 32'(tc_a), 32'(tv[k].tc));
        end

        // down from reset
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk("down_first_cnt", 32'(cnt_a), 9);
        chk("down_first_tc", 32'(tc_a), 1);
        for (int k = 0; k < 10; k++) drive(0, 1, 0, 0, 0, 0);
        chk("down_wrap_cnt", 32'(cnt_a), 9);
        chk("down_wrap_tc", 32'(tc_a), 1);

        // prescaler with a mid-interval freeze
        drive(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 1, 0, 0, 0);
        chk("pre_step_cnt", 32'(cnt_b), 1);
        chk("pre_step_tick", 32'(tick_b), 1);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("freeze_cnt", 32'(cnt_b), 1);
            chk("freeze_tick", 32'(tick_b), 0);
        end
        drive(0, 1, 1, 0, 0, 0);
        chk("resume_no_step", 32'(tick_b), 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("resume_step_cnt", 32'(cnt_b), 2);
        chk("resume_step_tick", 32'(tick_b), 1);

        // load, clamp, load+clear
        drive(0, 0, 1, 0, 1, 6'd7);
        chk("load7_a", 32'(cnt_a), 7);
        chk("load7_tc", 32'(tc_a), 0);
        drive(0, 0, 1, 0, 1, 6'd15);
        chk("load15_clamp_a", 32'(cnt_a), 9);
        chk("load15_c", 32'(cnt_c), 15);
        drive(0, 1, 1, 0, 1, 6'd10);
        chk("load10_clamp_a", 32'(cnt_a), 9);
        drive(0, 1, 1, 1, 1, 6'd5);
        chk("load_clear_a", 32'(cnt_a), 0);
        drive(0, 1, 0, 0, 1, 6'd0);
        chk("load0_tc", 32'(tc_a), 0);

        // reset mid-count: b at count 6, prescaler 2
        drive(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 26; k++) drive(0, 1, 1, 0, 0, 0);
        chk("mid_setup_cnt", 32'(cnt_b), 6);
        drive(1, 1, 1, 0, 1, 6'd5);
        chk("mid_rst_cnt", 32'(cnt_b), 0);
        chk("mid_rst_flags", 32'({tick_b, tc_b}), 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 0);
        chk("mid_pre_cnt", 32'(cnt_b), 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("mid_first_step", 32'(cnt_b), 1);
        chk("mid_first_tick", 32'(tick_b), 1);

        // full-range counter
        drive(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 15; k++) drive(0, 1, 1, 0, 0, 0);
        chk("full_top", 32'(cnt_c), 15);
        drive(0, 1, 1, 0, 0, 0);
        chk("full_wrap_cnt", 32'(cnt_c), 0);
        chk("full_wrap_tc", 32'(tc_c), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("full_down_wrap", 32'(cnt_c), 15);
        chk("full_down_tc", 32'(tc_c), 1);
        for (int k = 0; k < 40; k++) drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 20) == 0), 1'($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
